// File: rtl/risc_v_pipe_ctrl_pkg.sv
// Shared types and constants for the IF/ID pipeline sequencer and its hazard helper.
package risc_v_pipe_ctrl_pkg;

    localparam int          REG_W = 5;
    localparam logic [31:0] NOP   = 32'h00000013;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

endpackage

// File: rtl/risc_v_hazard_detect.sv
// Combinational load-use detector: the EX load writes a register the ID instruction reads.
module risc_v_hazard_detect
    import risc_v_pipe_ctrl_pkg::*;
(
    input  logic             mem_read_ex,
    input  logic [REG_W-1:0] rd_ex,
    input  logic [REG_W-1:0] rs1_id,
    input  logic [REG_W-1:0] rs2_id,
    input  logic             uses_rs2_id,
    output logic             lu
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign lu = mem_read_ex && (rd_ex != '0) &&
                ((rd_ex == rs1_id) || (uses_rs2_id && (rd_ex == rs2_id)));

endmodule

// File: rtl/risc_v_pipe_ctrl.sv
// IF/ID front-end sequencer: redirect / load-use / imem wait arbitration with a fetch timeout.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module risc_v_pipe_ctrl
    import risc_v_pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead_EX,
    input  logic [REG_W-1:0] RD_EX,
    input  logic [REG_W-1:0] RS1_ID,
    input  logic [REG_W-1:0] RS2_ID,
    input  logic             USES_RS2_ID,
    input  logic             PCSrc,
    input  logic             imem_ack,
    output logic             imem_req,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             fetch_timeout,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       lu, fetch_ok;
    logic       do_stall, do_bubble, do_flush;

    risc_v_hazard_detect u_hazard (
        .mem_read_ex (MemRead_EX),
        .rd_ex       (RD_EX),
        .rs1_id      (RS1_ID),
        .rs2_id      (RS2_ID),
        .uses_rs2_id (USES_RS2_ID),
        .lu          (lu)
    );

    assign fetch_ok      = ((state == ST_RUN) || (state == ST_WAIT)) && imem_ack;
    assign fetch_timeout = (state == ST_ERROR);
    assign state_o       = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Defaults are the safe "bubble everything" pattern used in reset and ERROR.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        imem_req     = 1'b0;
        PC_write     = 1'b0;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b1;
        ID_EX_flush  = 1'b1;
        do_stall     = 1'b0;
        do_bubble    = 1'b0;
        do_flush     = 1'b0;

        if (reset) begin
            imem_req = (state == ST_RUN) || (state == ST_WAIT);
            if (state == ST_ERROR) begin
                if (imem_ack)
                    wait_cnt_nxt = '0;
            end else begin
                if (PCSrc) begin
                    PC_write = 1'b1;
                    do_flush = 1'b1;
                end else if (lu) begin
                    IF_ID_write = 1'b0;
                    IF_ID_flush = 1'b0;
                    do_stall    = 1'b1;
                end else if (fetch_ok) begin
                    PC_write    = 1'b1;
                    IF_ID_flush = 1'b0;
                    ID_EX_flush = 1'b0;
                end else begin
                    ID_EX_flush = 1'b0;
                    do_bubble   = 1'b1;
                end

                // A redirect with the fetch still outstanding makes that word stale.
                if (imem_ack) begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == 8'(MAX_WAIT)) begin
                    state_nxt = ST_ERROR;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                    state_nxt    = ((state == ST_DRAIN) || PCSrc) ? ST_DRAIN : ST_WAIT;
                end
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, bubble_q, flush_q;

    // Saturating event counters; they hold at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            if (do_stall && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            if (do_bubble && (bubble_q != '1))
                bubble_q <= bubble_q + CNT_W'(1);
            if (do_flush && (flush_q != '1))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
    assign flush_cnt  = flush_q;
`else
    logic perf_unused;
    assign perf_unused = ^{do_stall, do_bubble, do_flush};
    assign stall_cnt   = '0;
    assign bubble_cnt  = '0;
    assign flush_cnt   = '0;
`endif

endmodule
